serial_mag_cmp_ctrl: RTL

- Sequencing controller that compares two W-bit unsigned operands by stepping one 2-bit comparator slice across them, most-significant slice first.
- Trades area for latency: one slice compare per clock instead of a full-width comparator.
- Sits between a requester (start/ready/done handshake) and the shared 2-bit compare datapath. Result flags are held until the next accepted request.

---
 rtl/serial_mag_cmp_ctrl_pkg.sv | 21 ++
 rtl/serial_mag_cmp_ctrl_if.sv | 28 ++
 rtl/serial_mag_cmp_ctrl_cmp2_slice.sv | 13 +
 rtl/serial_mag_cmp_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/serial_mag_cmp_ctrl_pkg.sv
// Shared definitions for the serial magnitude comparator controller.
// Holds the FSM state encoding and the one-hot {gt,eq,lt} result encoding.
package serial_cmp_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SCAN = ST_SCAN,
        FIN  = ST_FIN
    } state_t;

    // Result one-hot ordered as {gt, eq, lt}; RES_NONE means "not decided yet".
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

endpackage

// File: rtl/serial_mag_cmp_ctrl_if.sv
// Requester-side bus of the serial magnitude comparator.
//   start/a/b : request and operands (requester -> controller)
//   ready     : controller idle and able to accept
//   done      : one-cycle pulse when gt/eq/lt become valid
//   gt/eq/lt  : one-hot result, held until the next accepted request
// master = requester, slave = controller.
interface serial_mag_cmp_ctrl_if #(
    parameter int unsigned W = 8
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic         gt;
    logic         eq;
    logic         lt;

    modport master (
        output start, a, b,
        input  ready, done, gt, eq, lt
    );

    modport slave (
        input  start, a, b,
        output ready, done, gt, eq, lt
    );
endinterface

// File: rtl/serial_mag_cmp_ctrl_cmp2_slice.sv
// Combinational 2-bit unsigned magnitude compare slice.
//   x, y : 2-bit slice operands
//   x_gt : x > y
//   x_lt : x < y   (neither set means equal)
module cmp2_slice (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic       x_gt,
    output logic       x_lt
);
    assign x_gt = (x > y);
    assign x_lt = (x < y);
endmodule

// File: rtl/serial_mag_cmp_ctrl.sv
// Serial W-bit unsigned magnitude comparator controller.
// Steps one shared 2-bit compare slice over the latched operands, MS slice
// first, one slice per clock, and reports a registered one-hot gt/eq/lt.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of serial_mag_cmp_ctrl_if (start/a/b in,
//             ready/done/gt/eq/lt out, all outputs registered)
// Build option: define SERIAL_CMP_EARLY_EXIT_EN to leave the scan on the
// first unequal slice (variable latency); otherwise all NS slices are always
// visited and latency is constant.
module serial_mag_cmp_ctrl
    import serial_cmp_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    serial_mag_cmp_ctrl_if.slave bus
);

    localparam int unsigned NS = W / 2;
    localparam int unsigned IW = (NS > 1) ? $clog2(NS) : 1;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [W-1:0]  a_q,     a_d;
    logic [W-1:0]  b_q,     b_d;
    logic [2:0]    res_q,   res_d;
    logic          ready_q, ready_d;
    logic          done_q,  done_d;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
    // First unequal slice seen so far; later slices must not override it.
    logic [2:0]    pend_q,  pend_d;
    logic [2:0]    res_now;
`endif

    // Slice views of the latched operands, indexed by slice number.
    logic [1:0] a_sl [NS];
    logic [1:0] b_sl [NS];
    for (genvar g = 0; g < NS; g++) begin : g_slice
        assign a_sl[g] = a_q[2*g+1 -: 2];
        assign b_sl[g] = b_q[2*g+1 -: 2];
    end

    logic       sl_gt, sl_lt;
    logic [2:0] slice_res;

    // Single shared slice comparator, muxed by the current slice index.
    cmp2_slice u_slice (
        .x    (a_sl[idx_q]),
        .y    (b_sl[idx_q]),
        .x_gt (sl_gt),
        .x_lt (sl_lt)
    );

    assign slice_res = sl_gt ? RES_GT : (sl_lt ? RES_LT : RES_NONE);

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= RES_NONE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
            pend_q  <= RES_NONE;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ready_q <= ready_d;
            done_q  <= done_d;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
            pend_q  <= pend_d;
`endif
        end
    end

    // Next-state and next-register values.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
        pend_d  = pend_q;
        res_now = (pend_q != RES_NONE) ? pend_q : slice_res;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    idx_d   = IW'(NS - 1);
                    res_d   = RES_NONE;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
                    pend_d  = RES_NONE;
`endif
                    state_d = SCAN;
                end
            end

            SCAN: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                if (slice_res != RES_NONE) begin
                    res_d   = slice_res;
                    state_d = FIN;
                end else if (idx_q == '0) begin
                    res_d   = RES_EQ;
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q - IW'(1);
                end
`else
                pend_d = res_now;
                if (idx_q == '0) begin
                    res_d   = (res_now != RES_NONE) ? res_now : RES_EQ;
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q - IW'(1);
                end
`endif
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the state being entered.
        ready_d = (state_d == IDLE);
        done_d  = (state_d == FIN);
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.gt    = res_q[2];
    assign bus.eq    = res_q[1];
    assign bus.lt    = res_q[0];

endmodule
